// File: rtl/msk_aes_stream_host_if.sv
// Stream-fabric and masked-AES-core signal bundle for msk_aes_stream_host.
// master = the host block, slave = the surrounding fabric/core/testbench.
interface msk_aes_stream_host_if #(
  parameter int d = 2
) ();
  logic [31:0]        s_data;
  logic               s_valid;
  logic               s_ready;
  logic [31:0]        m_data;
  logic               m_valid;
  logic               m_last;
  logic               m_ready;
  logic               core_valid_in;
  logic               core_in_ready;
  logic               core_inverse;
  logic               core_key_schedule_only;
  logic [128*d-1:0]   core_sh_plaintext;
  logic [128*d-1:0]   core_sh_key;
  logic               core_cipher_valid;
  logic               core_out_ready;
  logic [128*d-1:0]   core_sh_ciphertext;
  logic               busy;

  modport master (
    input  s_data, s_valid, m_ready, core_in_ready, core_cipher_valid, core_sh_ciphertext,
    output s_ready, m_data, m_valid, m_last, core_valid_in, core_inverse,
           core_key_schedule_only, core_sh_plaintext, core_sh_key, core_out_ready, busy
  );

  modport slave (
    output s_data, s_valid, m_ready, core_in_ready, core_cipher_valid, core_sh_ciphertext,
    input  s_ready, m_data, m_valid, m_last, core_valid_in, core_inverse,
           core_key_schedule_only, core_sh_plaintext, core_sh_key, core_out_ready, busy
  );
endinterface

// File: rtl/msk_aes_stream_host.sv
// Assembles header + shared plaintext/key from a 32-bit stream, runs one masked-AES op, streams ciphertext shares back.
// Latency: core_valid_in one cycle after the last input word; each side stalls cleanly on its own valid/ready.
module msk_aes_stream_host #(
  parameter int d = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  msk_aes_stream_host_if.master  bus_io
);

  localparam int W    = 128 * d;
  localparam int NW   = 4 * d;
  localparam int CW   = $clog2(8 * d + 1);
  localparam int OW   = $clog2(4 * d);
  localparam logic [CW-1:0] CNT_LAST  = CW'(8 * d);
  localparam logic [CW-1:0] CNT_PTEND = CW'(NW);
  localparam logic [OW-1:0] OCNT_LAST = OW'(NW - 1);

  typedef enum logic [1:0] {
    S_COLLECT = 2'd0,
    S_ISSUE   = 2'd1,
    S_WAIT    = 2'd2,
    S_DRAIN   = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [OW-1:0]   ocnt_q, ocnt_d;
  logic            inv_q, inv_d;
  logic            kso_q, kso_d;
  logic [W-1:0]    pt_q, pt_d;
  logic [W-1:0]    key_q, key_d;
  logic [W-1:0]    cbuf_q, cbuf_d;

  logic            s_ready;
  logic            m_valid;
  logic            m_last;
  logic [31:0]     m_data;
  logic            core_valid_in;
  logic            core_out_ready;
  logic            core_inverse;
  logic            core_kso;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_COLLECT;
      cnt_q   <= '0;
      ocnt_q  <= '0;
      inv_q   <= 1'b0;
      kso_q   <= 1'b0;
      pt_q    <= '0;
      key_q   <= '0;
      cbuf_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ocnt_q  <= ocnt_d;
      inv_q   <= inv_d;
      kso_q   <= kso_d;
      pt_q    <= pt_d;
      key_q   <= key_d;
      cbuf_q  <= cbuf_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    ocnt_d         = ocnt_q;
    inv_d          = inv_q;
    kso_d          = kso_q;
    pt_d           = pt_q;
    key_d          = key_q;
    cbuf_d         = cbuf_q;
    s_ready        = 1'b0;
    m_valid        = 1'b0;
    m_last         = 1'b0;
    m_data         = '0;
    core_valid_in  = 1'b0;
    core_out_ready = 1'b0;
    core_inverse   = 1'b0;
    core_kso       = 1'b0;

    unique case (state_q)
      S_COLLECT: begin
        // Gated by rst_n so every output reads 0 while reset is held.
        s_ready = rst_n;
        if (bus_io.s_valid) begin
          if (cnt_q == '0) begin
            inv_d = bus_io.s_data[0];
            kso_d = bus_io.s_data[1];
          end else if (cnt_q <= CNT_PTEND) begin
            pt_d[32*(int'(cnt_q) - 1) +: 32] = bus_io.s_data;
          end else begin
            key_d[32*(int'(cnt_q) - NW - 1) +: 32] = bus_io.s_data;
          end
          if (cnt_q == CNT_LAST) begin
            cnt_d   = '0;
            state_d = S_ISSUE;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end

      S_ISSUE: begin
        core_valid_in = 1'b1;
        core_inverse  = inv_q;
        core_kso      = kso_q;
        // Core samples the shares on this edge, so they are wiped on the same edge and not before.
        if (bus_io.core_in_ready) begin
          pt_d    = '0;
          key_d   = '0;
          inv_d   = 1'b0;
          kso_d   = 1'b0;
          state_d = S_WAIT;
        end
      end

      S_WAIT: begin
        core_out_ready = 1'b1;
        if (bus_io.core_cipher_valid) begin
          cbuf_d  = bus_io.core_sh_ciphertext;
          state_d = S_DRAIN;
        end
      end

      S_DRAIN: begin
        m_valid = 1'b1;
        m_data  = cbuf_q[32*int'(ocnt_q) +: 32];
        m_last  = (ocnt_q == OCNT_LAST);
        if (bus_io.m_ready) begin
          if (ocnt_q == OCNT_LAST) begin
            cbuf_d  = '0;
            ocnt_d  = '0;
            state_d = S_COLLECT;
          end else begin
            ocnt_d = ocnt_q + OW'(1);
          end
        end
      end

      default: state_d = S_COLLECT;
    endcase
  end

  assign bus_io.s_ready                = s_ready;
  assign bus_io.m_valid                = m_valid;
  assign bus_io.m_last                 = m_last;
  assign bus_io.m_data                 = m_data;
  assign bus_io.core_valid_in          = core_valid_in;
  assign bus_io.core_out_ready         = core_out_ready;
  assign bus_io.core_inverse           = core_inverse;
  assign bus_io.core_key_schedule_only = core_kso;
  assign bus_io.core_sh_plaintext      = pt_q;
  assign bus_io.core_sh_key            = key_q;
  assign bus_io.busy                   = !((state_q == S_COLLECT) && (cnt_q == '0));

endmodule

// File: tb/tb_msk_aes_stream_host.sv
// Directed bench for msk_aes_stream_host: stimulus pushes expected ciphertext words into a
// scoreboard queue, an independent monitor pops and compares on every output handshake.
module tb_msk_aes_stream_host;
  localparam int D  = 2;
  localparam int W  = 128 * D;
  localparam int NW = 4 * D;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  msk_aes_stream_host_if #(.d(D)) bus ();

  msk_aes_stream_host #(.d(D)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus_io (bus.master)
  );

  int          checks = 0;
  int          errors = 0;
  int          hs_count = 0;
  logic        toggle_mode = 1'b0;
  logic [32:0] sb_q[$];

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // m_ready: always high, or toggling every cycle when toggle_mode is set
  initial begin
    bus.m_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      bus.m_ready = toggle_mode ? ~bus.m_ready : 1'b1;
    end
  end

  // Output monitor / scoreboard
  initial begin
    logic        pv;
    logic [31:0] pd;
    logic        pl;
    logic [32:0] e;
    pv = 1'b0;
    pd = '0;
    pl = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        pv = 1'b0;
      end else begin
        if (bus.core_valid_in && bus.core_in_ready) hs_count++;
        if (bus.m_valid) check("s_ready_low_in_drain", W'(bus.s_ready), '0);
        if (pv && bus.m_valid) begin
          check("m_data_hold", W'(bus.m_data), W'(pd));
          check("m_last_hold", W'(bus.m_last), W'(pl));
        end
        if (bus.m_valid && bus.m_ready) begin
          if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_underflow: got word %h expected none", bus.m_data);
          end else begin
            e = sb_q.pop_front();
            check("m_data", W'(bus.m_data), W'(e[31:0]));
            check("m_last", W'(bus.m_last), W'(e[32]));
          end
        end
        pv = bus.m_valid && !bus.m_ready;
        pd = bus.m_data;
        pl = bus.m_last;
      end
    end
  end

  task automatic send_word(input logic [31:0] w);
    int n;
    n = 0;
    bus.s_data  = w;
    bus.s_valid = 1'b1;
    @(negedge clk);
    while (!bus.s_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!bus.s_ready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: got s_ready 0 expected 1 for word %h", w);
    end
    @(posedge clk);
    #1;
    bus.s_valid = 1'b0;
  endtask

  function automatic logic [W-1:0] vec(input logic [31:0] base, input int off);
    logic [W-1:0] v;
    v = '0;
    for (int k = 0; k < NW; k++) v[32*k +: 32] = base + 32'(k + off);
    return v;
  endfunction

  // One full transaction; in_ready is held low for 1+extra cycles of ISSUE.
  task automatic do_txn(input logic [31:0] hdr, input logic [31:0] ptb, input logic [31:0] kb,
                        input logic [31:0] ctb, input int extra);
    logic [W-1:0] ept, ekey, ect;
    int hs0, n;
    ept  = vec(ptb, 1);
    ekey = vec(kb, 1);
    ect  = vec(ctb, 0);
    hs0  = hs_count;
    send_word(hdr);
    for (int k = 0; k < NW; k++) send_word(ept[32*k +: 32]);
    for (int k = 0; k < NW; k++) send_word(ekey[32*k +: 32]);
    @(negedge clk);
    check("valid_in_after_last_word", W'(bus.core_valid_in), W'(1));
    check("inverse_in_issue", W'(bus.core_inverse), W'(hdr[0]));
    check("kso_in_issue", W'(bus.core_key_schedule_only), W'(hdr[1]));
    check("sh_plaintext", bus.core_sh_plaintext, ept);
    check("sh_key", bus.core_sh_key, ekey);
    check("s_ready_in_issue", W'(bus.s_ready), '0);
    check("busy_in_issue", W'(bus.busy), W'(1));
    for (int i = 0; i < extra; i++) begin
      @(negedge clk);
      check("valid_in_stall", W'(bus.core_valid_in), W'(1));
      check("pt_stall", bus.core_sh_plaintext, ept);
      check("key_stall", bus.core_sh_key, ekey);
    end
    @(posedge clk);
    #1;
    bus.core_in_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.core_in_ready = 1'b0;
    @(negedge clk);
    check("valid_in_after_hs", W'(bus.core_valid_in), '0);
    check("pt_zeroized", bus.core_sh_plaintext, '0);
    check("key_zeroized", bus.core_sh_key, '0);
    check("inverse_after_issue", W'(bus.core_inverse), '0);
    check("kso_after_issue", W'(bus.core_key_schedule_only), '0);
    check("issue_handshakes", W'(hs_count - hs0), W'(1));
    repeat (2) begin
      @(negedge clk);
      check("out_ready_in_wait", W'(bus.core_out_ready), W'(1));
    end
    @(posedge clk);
    #1;
    for (int k = 0; k < NW; k++) sb_q.push_back({(k == NW - 1), ect[32*k +: 32]});
    bus.core_sh_ciphertext = ect;
    bus.core_cipher_valid  = 1'b1;
    @(posedge clk);
    #1;
    bus.core_cipher_valid  = 1'b0;
    bus.core_sh_ciphertext = '0;
    @(negedge clk);
    check("out_ready_after_capture", W'(bus.core_out_ready), '0);
    check("m_valid_after_capture", W'(bus.m_valid), W'(1));
    n = 0;
    while (n < 200 && (sb_q.size() != 0 || bus.m_valid)) begin
      @(negedge clk);
      n++;
    end
    check("drain_within_budget", W'(n < 200), W'(1));
    check("s_ready_after_drain", W'(bus.s_ready), W'(1));
    check("busy_idle", W'(bus.busy), '0);
    check("m_data_idle", W'(bus.m_data), '0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus.s_data             = '0;
    bus.s_valid            = 1'b0;
    bus.core_in_ready      = 1'b0;
    bus.core_cipher_valid  = 1'b0;
    bus.core_sh_ciphertext = '0;

    #12;
    check("reset_ctrl", W'({bus.s_ready, bus.m_valid, bus.m_last, bus.core_valid_in, bus.core_out_ready,
                            bus.core_inverse, bus.core_key_schedule_only, bus.busy}), '0);
    check("reset_m_data", W'(bus.m_data), '0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_s_ready", W'(bus.s_ready), W'(1));
    check("idle_busy", W'(bus.busy), '0);
    @(posedge clk);
    #1;

    do_txn(32'h0000_0000, 32'h0000_0000, 32'h1000_0000, 32'hC0DE_0000, 0);

    toggle_mode = 1'b1;
    do_txn(32'hFFFF_FFF3, 32'hA5A5_0000, 32'h5A5A_0000, 32'hBEEF_0100, 4);

    // Abort after 9 of 17 words
    send_word(32'h0000_0002);
    for (int k = 0; k < NW; k++) send_word(32'hDEAD_0000 + 32'(k));
    #3;
    rst_n = 1'b0;
    #1;
    check("abort_ctrl", W'({bus.s_ready, bus.m_valid, bus.m_last, bus.core_valid_in, bus.core_out_ready,
                            bus.core_inverse, bus.core_key_schedule_only, bus.busy}), '0);
    check("abort_pt", bus.core_sh_plaintext, '0);
    check("abort_key", bus.core_sh_key, '0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    do_txn(32'h0000_0001, 32'h7000_0010, 32'h3000_0020, 32'h1234_0000, 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
